// File: rtl/ubrcl_seq_ctrl.sv
// ubrcl_seq_ctrl
// ----------------------------------------------------------------------------
// Wide-add sequencer. One operand pair of N = LIMB_W*LIMBS bits is split into
// LIMBS limbs and pushed through a single external combinational LIMB_W-bit
// adder core, one limb per cycle, least significant limb first. The core's
// carry-out is registered and fed back as the next limb's carry-in. The
// assembled (N+1)-bit sum is returned over a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state (never on in_valid). out_valid
// is registered and, once high, holds with out_s stable until out_ready.
//
// Optional feature: define SEQ_SUB_EN to add the op_sub input. With
// op_sub=1 the block computes X-Y (Y limbs inverted, initial carry 1) and
// out_s[N] is the inverted borrow.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake, in_x/in_y operands (N bits)
//   op_sub              subtract select (SEQ_SUB_EN builds only)
//   out_valid/out_ready result handshake, out_s sum (N+1 bits)
//   busy                high whenever the FSM is not IDLE
//   fsm_state           debug view of the FSM state register
//   add_x/add_y/add_cin limb operands and carry-in to the adder core
//   add_s               adder core result, bit LIMB_W is its carry-out
// ----------------------------------------------------------------------------
module ubrcl_seq_ctrl #(
    parameter int LIMB_W = 23,
    parameter int LIMBS  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LIMB_W*LIMBS-1:0]    in_x,
    input  logic [LIMB_W*LIMBS-1:0]    in_y,
`ifdef SEQ_SUB_EN
    input  logic                       op_sub,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LIMB_W*LIMBS:0]      out_s,
    output logic                       busy,
    output logic [1:0]                 fsm_state,
    output logic [LIMB_W-1:0]          add_x,
    output logic [LIMB_W-1:0]          add_y,
    output logic                       add_cin,
    input  logic [LIMB_W:0]            add_s
);

    localparam int N  = LIMB_W * LIMBS;
    localparam int KW = $clog2(LIMBS);
    localparam logic [KW-1:0] K_LAST = KW'(LIMBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      x_q, y_q;
    logic [N:0]        sum_q;
    logic              carry_q;
    logic [KW-1:0]     k_q;
    logic              out_valid_q;
    logic              sub_q;
    logic              init_carry;
    logic              last_limb;
    logic [LIMB_W-1:0] x_limb, y_limb;

`ifdef SEQ_SUB_EN
    // Subtraction is X + ~Y + 1, so the initial carry doubles as the "+1".
    assign init_carry = op_sub;
`else
    assign init_carry = 1'b0;
    assign sub_q      = 1'b0;
`endif

    assign last_limb = (k_q == K_LAST);
    assign x_limb    = x_q[int'(k_q)*LIMB_W +: LIMB_W];
    assign y_limb    = y_q[int'(k_q)*LIMB_W +: LIMB_W] ^ {LIMB_W{sub_q}};

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_s     = sum_q;
    assign fsm_state = state_q;

    // Next state and adder-core drive; the core sees zeros outside RUN.
    always_comb begin
        state_d = state_q;
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                add_x   = x_limb;
                add_y   = y_limb;
                add_cin = carry_q;
                if (last_limb) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_x;
                        y_q     <= in_y;
                        carry_q <= init_carry;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    sum_q[int'(k_q)*LIMB_W +: LIMB_W] <= add_s[LIMB_W-1:0];
                    carry_q <= add_s[LIMB_W];
                    if (last_limb) begin
                        // Final core carry becomes the top result bit.
                        sum_q[N]    <= add_s[LIMB_W];
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            sub_q <= op_sub;
        end
    end
`endif

endmodule

// File: tb/tb_ubrcl_seq_ctrl.sv
module tb_ubrcl_seq_ctrl;

    localparam int LIMB_W = 23;
    localparam int LIMBS  = 4;
    localparam int N      = LIMB_W * LIMBS;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [N-1:0]      in_x      = '0;
    logic [N-1:0]      in_y      = '0;
`ifdef SEQ_SUB_EN
    logic              op_sub    = 1'b0;
`endif
    logic              in_ready, out_valid, busy, add_cin;
    logic [N:0]        out_s;
    logic [1:0]        fsm_state;
    logic [LIMB_W-1:0] add_x, add_y;
    logic [LIMB_W:0]   add_s;

    // Behavioural model of the shared combinational adder core.
    assign add_s = {1'b0, add_x} + {1'b0, add_y} + {{LIMB_W{1'b0}}, add_cin};

    ubrcl_seq_ctrl #(.LIMB_W(LIMB_W), .LIMBS(LIMBS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
`ifdef SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .busy      (busy),
        .fsm_state (fsm_state),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_cin   (add_cin),
        .add_s     (add_s)
    );

    // ---------------- scoreboard ----------------
    logic [N:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [N-1:0] rand_n();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[N-1:0];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_add_x"},     add_x,     '0);
        check({tag, "_add_y"},     add_y,     '0);
        check({tag, "_add_cin"},   add_cin,   1'b0);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the result handshake.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic sub, input int stall);
        logic [N:0]        e, snap;
        logic [LIMB_W-1:0] xl, yl;
        logic [LIMB_W:0]   t;
        logic              c;
        int                w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
`ifdef SEQ_SUB_EN
        op_sub   = sub;
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x     = rand_n();
        in_y     = rand_n();
`ifdef SEQ_SUB_EN
        op_sub   = $urandom_range(0, 1);
`endif
        if (sub) e = {1'b0, x} + {1'b0, ~y} + (N+1)'(1);
        else     e = {1'b0, x} + {1'b0, y};
        exp_q.push_back(e);
        c = sub;
        for (int k = 0; k < LIMBS; k++) begin
            @(negedge clk);
            xl = x[k*LIMB_W +: LIMB_W];
            yl = sub ? ~y[k*LIMB_W +: LIMB_W] : y[k*LIMB_W +: LIMB_W];
            check("run_add_x",     add_x,     xl);
            check("run_add_y",     add_y,     yl);
            check("run_add_cin",   add_cin,   c);
            check("run_out_valid", out_valid, 1'b0);
            check("run_busy",      busy,      1'b1);
            check("run_in_ready",  in_ready,  1'b0);
            t = {1'b0, xl} + {1'b0, yl} + {{LIMB_W{1'b0}}, c};
            c = t[LIMB_W];
        end
        @(negedge clk);
        check("latency_out_valid", out_valid, 1'b1);
        check("done_add_x",   add_x,   '0);
        check("done_add_y",   add_y,   '0);
        check("done_add_cin", add_cin, 1'b0);
        snap = out_s;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_x     = rand_n();
            in_y     = rand_n();
            @(negedge clk);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_s",     out_s,     snap);
            check("stall_in_ready",  in_ready,  1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (exp_q.size() == 0) check("queue_underflow", 1'b1, 1'b0);
        else                   check("result", out_s, exp_q.pop_front());
        check("result_top_bit", out_s[N], e[N]);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_done");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0] all_ones;
        logic         rsub;
        all_ones = '1;

        #1;
        check_idle_outputs("reset");
        check("reset_out_s", out_s, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Inter-limb carry from limb 0 into limb 1.
        run_op(N'(23'h7FFFFF), N'(1), 1'b0, 0);
        // Carry ripples through every limb into the top bit.
        run_op(all_ones, N'(1), 1'b0, 1);
        // Back-to-back with stalled consumer; second op issued immediately.
        run_op(rand_n(), rand_n(), 1'b0, 3);
        run_op(rand_n(), rand_n(), 1'b0, 0);

        // Reset in the second RUN cycle discards the operation.
        in_valid = 1'b1;
        in_x     = N'(100);
        in_y     = N'(200);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        check("mid_reset_out_s", out_s, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_valid_after_reset", out_valid, 1'b0);
            check("idle_after_reset",     busy,      1'b0);
        end
        run_op(N'(3), N'(4), 1'b0, 0);

`ifdef SEQ_SUB_EN
        run_op(N'(5), N'(7), 1'b1, 0);
        run_op(N'(7), N'(5), 1'b1, 2);
`endif

        for (int i = 0; i < 1000; i++) begin
            rsub = 1'b0;
`ifdef SEQ_SUB_EN
            rsub = $urandom_range(0, 1);
`endif
            run_op(($urandom_range(0, 7) == 0) ? all_ones : rand_n(),
                   ($urandom_range(0, 7) == 0) ? all_ones : rand_n(),
                   rsub, $urandom_range(0, 3));
        end

        check("queue_empty", exp_q.size(), '0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
